// File: rtl/midi_voice_alloc_if.sv
// Event bus between the MIDI command decoder (master) and the voice allocator (slave).
// The note/velocity/channel fields are valid only while a pulse is high.
interface midi_voice_alloc_if;
  logic       note_on;
  logic       note_off;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic       busy;

  modport master (output note_on, note_off, note, velocity, channel, input busy);
  modport slave  (input note_on, note_off, note, velocity, channel, output busy);
endinterface

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: each accepted event scans one voice per cycle,
// then commits to a retriggered, free or stolen (oldest) voice.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  midi_voice_alloc_if.slave       if_evt,
  output logic [NUM_VOICES-1:0]   o_voice_gate,
  output logic [NUM_VOICES-1:0]   o_voice_trig,
  output logic [NUM_VOICES-1:0]   o_voice_rel,
  output logic [7*NUM_VOICES-1:0] o_voice_note,
  output logic [7*NUM_VOICES-1:0] o_voice_vel,
  output logic [4*NUM_VOICES-1:0] o_voice_chan,
  output logic                    o_steal,
  output logic [7:0]              o_drop_cnt
);

  localparam int                IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;

  // Latched event
  logic             r_ev_on;
  logic [6:0]       r_ev_note;
  logic [6:0]       r_ev_vel;
  logic [3:0]       r_ev_chan;

  // Scan results
  logic             r_match_ok;
  logic [IDX_W-1:0] r_match_idx;
  logic             r_free_ok;
  logic [IDX_W-1:0] r_free_idx;
  logic             r_old_ok;
  logic [IDX_W-1:0] r_old_idx;
  logic [AGE_W-1:0] r_old_age;

  // Per-voice state
  logic [NUM_VOICES-1:0]             r_gate;
  logic [NUM_VOICES-1:0]             r_trig;
  logic [NUM_VOICES-1:0]             r_rel;
  logic [NUM_VOICES-1:0][6:0]        r_note;
  logic [NUM_VOICES-1:0][6:0]        r_vel;
  logic [NUM_VOICES-1:0][3:0]        r_chan;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  r_age;
  logic                              r_steal;
  logic [7:0]                        r_drop;

  logic             w_idle;
  logic             w_pulse;
  logic             w_drop;
  logic             w_cur_match;
  logic [IDX_W-1:0] w_tgt_idx;

  assign w_idle  = (r_state == S_IDLE);
  assign w_pulse = if_evt.note_on | if_evt.note_off;
  // A simultaneous note_off loses to note_on and counts as a dropped event.
  assign w_drop  = (!w_idle && w_pulse) || (w_idle && if_evt.note_on && if_evt.note_off);

  assign w_cur_match = r_gate[r_idx] && (r_note[r_idx] == r_ev_note) && (r_chan[r_idx] == r_ev_chan);

  always_comb begin
    w_tgt_idx = r_old_idx;
    if (r_match_ok)     w_tgt_idx = r_match_idx;
    else if (r_free_ok) w_tgt_idx = r_free_idx;
  end

  // NOTE: all state below is plain flops (no RAM), so the synchronous reset clears every voice register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ev_on     <= 1'b0;
      r_ev_note   <= '0;
      r_ev_vel    <= '0;
      r_ev_chan   <= '0;
      r_match_ok  <= 1'b0;
      r_match_idx <= '0;
      r_free_ok   <= 1'b0;
      r_free_idx  <= '0;
      r_old_ok    <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
      r_gate      <= '0;
      r_trig      <= '0;
      r_rel       <= '0;
      r_note      <= '0;
      r_vel       <= '0;
      r_chan      <= '0;
      r_age       <= '0;
      r_steal     <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_trig  <= '0;
      r_rel   <= '0;
      r_steal <= 1'b0;

      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_pulse) begin
            r_ev_on    <= if_evt.note_on && (if_evt.velocity != 7'd0);
            r_ev_note  <= if_evt.note;
            r_ev_vel   <= if_evt.velocity;
            r_ev_chan  <= if_evt.channel;
            r_match_ok <= 1'b0;
            r_free_ok  <= 1'b0;
            r_old_ok   <= 1'b0;
            r_idx      <= '0;
            r_state    <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (r_gate[r_idx]) begin
            if (!r_match_ok && w_cur_match) begin
              r_match_ok  <= 1'b1;
              r_match_idx <= r_idx;
            end
            // Strict compare keeps the lowest index on an age tie.
            if (!r_old_ok || r_age[r_idx] > r_old_age) begin
              r_old_ok  <= 1'b1;
              r_old_idx <= r_idx;
              r_old_age <= r_age[r_idx];
            end
          end else if (!r_free_ok) begin
            r_free_ok  <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (r_idx == LAST_IDX) r_state <= S_COMMIT;
          else                   r_idx   <= r_idx + 1'b1;
        end

        S_COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_ev_on) begin
              if (w_tgt_idx == IDX_W'(i)) begin
                r_gate[i] <= 1'b1;
                r_note[i] <= r_ev_note;
                r_vel[i]  <= r_ev_vel;
                r_chan[i] <= r_ev_chan;
                r_age[i]  <= '0;
                r_trig[i] <= 1'b1;
              end else if (r_gate[i] && r_age[i] != AGE_MAX) begin
                r_age[i] <= r_age[i] + 1'b1;
              end
            end else if (r_match_ok && r_match_idx == IDX_W'(i)) begin
              // Pitch, velocity and channel hold so the release tail keeps sounding the same note.
              r_gate[i] <= 1'b0;
              r_rel[i]  <= 1'b1;
            end
          end
          r_steal <= r_ev_on && !r_match_ok && !r_free_ok;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_evt.busy  = !w_idle;
  assign o_voice_gate = r_gate;
  assign o_voice_trig = r_trig;
  assign o_voice_rel  = r_rel;
  assign o_voice_note = r_note;
  assign o_voice_vel  = r_vel;
  assign o_voice_chan = r_chan;
  assign o_steal      = r_steal;
  assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc: a behavioural voice model pushes the
// expected result of each event to a scoreboard, popped when the FSM returns to idle.
module tb_midi_voice_alloc;

  localparam int NV = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_voice_alloc_if evt();

  logic [NV-1:0]   voice_gate, voice_trig, voice_rel;
  logic [7*NV-1:0] voice_note, voice_vel;
  logic [4*NV-1:0] voice_chan;
  logic            steal;
  logic [7:0]      drop_cnt;

  midi_voice_alloc #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_evt       (evt.slave),
    .o_voice_gate (voice_gate),
    .o_voice_trig (voice_trig),
    .o_voice_rel  (voice_rel),
    .o_voice_note (voice_note),
    .o_voice_vel  (voice_vel),
    .o_voice_chan (voice_chan),
    .o_steal      (steal),
    .o_drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic [NV-1:0]   trig;
    logic [NV-1:0]   rel;
    logic            steal;
    logic [NV-1:0]   gate;
    logic [7*NV-1:0] notes;
    logic [7*NV-1:0] vels;
    logic [4*NV-1:0] chans;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference voice model
  logic       m_gate[NV];
  logic [6:0] m_note[NV];
  logic [6:0] m_vel[NV];
  logic [3:0] m_chan[NV];
  int         m_age[NV];
  int         m_drop;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0; m_chan[i] = '0; m_age[i] = 0;
    end
    m_drop = 0;
  endfunction

  function automatic void model_drop();
    if (m_drop < 255) m_drop++;
  endfunction

  function automatic exp_t model_event(input bit is_on, input logic [6:0] n, input logic [6:0] v,
                                       input logic [3:0] c);
    exp_t e;
    int   tgt = -1;
    e.trig  = '0;
    e.rel   = '0;
    e.steal = 1'b0;
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && m_gate[i] && m_note[i] == n && m_chan[i] == c) tgt = i;
    if (is_on) begin
      if (tgt < 0)
        for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
        e.steal = 1'b1;
      end
      for (int i = 0; i < NV; i++) begin
        if (i == tgt) begin
          m_gate[i] = 1'b1; m_note[i] = n; m_vel[i] = v; m_chan[i] = c; m_age[i] = 0;
        end else if (m_gate[i] && m_age[i] < (1 << AW) - 1) begin
          m_age[i]++;
        end
      end
      e.trig[tgt] = 1'b1;
    end else if (tgt >= 0) begin
      m_gate[tgt] = 1'b0;
      e.rel[tgt]  = 1'b1;
    end
    for (int i = 0; i < NV; i++) begin
      e.gate[i]        = m_gate[i];
      e.notes[7*i +: 7] = m_note[i];
      e.vels[7*i +: 7]  = m_vel[i];
      e.chans[4*i +: 4] = m_chan[i];
    end
    return e;
  endfunction

  task automatic idle_inputs();
    evt.note_on = 1'b0; evt.note_off = 1'b0;
    evt.note = '0; evt.velocity = '0; evt.channel = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Drives one pulse; returns at the negedge after the sampling edge with busy expected high.
  task automatic send(input bit now, input bit on, input bit off, input logic [6:0] n,
                      input logic [6:0] v, input logic [3:0] c);
    if (!now) @(negedge clk);
    evt.note_on = on; evt.note_off = off;
    evt.note = n; evt.velocity = v; evt.channel = c;
    if (on && off) model_drop();
    sb.push_back(model_event(on && (v != 7'd0), n, v, c));
    @(negedge clk);
    idle_inputs();
    n_vec++;
    if (evt.busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_busy note=%0d got busy=%b want 1", n, evt.busy);
    end
  endtask

  // Waits for the update, pops the expectation and compares the voice outputs.
  task automatic wait_result(input string name, input int pre, input bit trail);
    int   cnt = pre;
    exp_t e;
    while (evt.busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (evt.busy !== 1'b0 || cnt != NV + 1) begin
      n_err++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, cnt, NV + 1);
    end
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (voice_trig !== e.trig || voice_rel !== e.rel || steal !== e.steal) begin
        n_err++;
        $display("FAIL %s pulses got trig=%b rel=%b steal=%b want trig=%b rel=%b steal=%b",
                 name, voice_trig, voice_rel, steal, e.trig, e.rel, e.steal);
      end
      n_vec++;
      if (voice_gate !== e.gate) begin
        n_err++;
        $display("FAIL %s gate got %b want %b", name, voice_gate, e.gate);
      end
      n_vec++;
      if (voice_note !== e.notes || voice_vel !== e.vels || voice_chan !== e.chans) begin
        n_err++;
        $display("FAIL %s regs got note=%h vel=%h chan=%h want note=%h vel=%h chan=%h",
                 name, voice_note, voice_vel, voice_chan, e.notes, e.vels, e.chans);
      end
      n_vec++;
      if (drop_cnt !== 8'(m_drop)) begin
        n_err++;
        $display("FAIL %s drop_cnt got %0d want %0d", name, drop_cnt, m_drop);
      end
    end
    if (trail) begin
      @(negedge clk);
      n_vec++;
      if (voice_trig !== '0 || voice_rel !== '0 || steal !== 1'b0) begin
        n_err++;
        $display("FAIL %s pulse_width got trig=%b rel=%b steal=%b want 0", name, voice_trig, voice_rel, steal);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (voice_gate !== '0 || voice_trig !== '0 || voice_rel !== '0 || voice_note !== '0 ||
        voice_vel !== '0 || voice_chan !== '0 || steal !== 1'b0 || drop_cnt !== '0 || evt.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got gate=%b note=%h drop=%0d busy=%b want all 0",
               voice_gate, voice_note, drop_cnt, evt.busy);
    end
  endtask

  task automatic test_fill_steal();
    logic [6:0] notes[5] = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b1, 1'b0, notes[i], 7'd100, 4'd0);
      wait_result($sformatf("fill_%0d", notes[i]), 0, 1'b1);
    end
    n_vec++;
    if (voice_gate !== 4'hF || voice_note[6:0] !== 7'd67) begin
      n_err++;
      $display("FAIL steal_target got gate=%b v0note=%0d want gate=1111 v0note=67", voice_gate, voice_note[6:0]);
    end
  endtask

  task automatic test_release();
    do_reset();
    send(1'b0, 1'b1, 1'b0, 7'd60, 7'd90, 4'd0); wait_result("rel_fill0", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd62, 7'd91, 4'd0); wait_result("rel_fill1", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd64, 7'd92, 4'd0); wait_result("rel_fill2", 0, 1'b1);
    send(1'b0, 1'b0, 1'b1, 7'd62, 7'd0,  4'd0); wait_result("note_off_62", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd70, 7'd80, 4'd0); wait_result("reuse_free", 0, 1'b1);
    n_vec++;
    if (voice_note[13:7] !== 7'd70) begin
      n_err++;
      $display("FAIL reuse_voice1 got v1note=%0d want 70", voice_note[13:7]);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(1'b0, 1'b1, 1'b0, 7'd60, 7'd100, 4'd0); wait_result("retrig_first", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd60, 7'd40,  4'd0); wait_result("retrig_same", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd60, 7'd50,  4'd1); wait_result("retrig_other_chan", 0, 1'b1);
  endtask

  task automatic test_vel0_and_orphan_off();
    do_reset();
    send(1'b0, 1'b1, 1'b0, 7'd60, 7'd100, 4'd0); wait_result("v0_fill0", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd62, 7'd100, 4'd0); wait_result("v0_fill1", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd72, 7'd100, 4'd0); wait_result("v0_fill2", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd72, 7'd0,   4'd0); wait_result("vel0_release", 0, 1'b1);
    send(1'b0, 1'b0, 1'b1, 7'd99, 7'd0,   4'd0); wait_result("orphan_off", 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(1'b0, 1'b1, 1'b0, 7'd48, 7'd10, 4'd3); wait_result("b2b_0", 0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 7'd50, 7'd20, 4'd3); wait_result("b2b_1", 0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 7'd48, 7'd0,  4'd3); wait_result("b2b_2", 0, 1'b1);
  endtask

  task automatic test_drops();
    do_reset();
    send(1'b0, 1'b1, 1'b1, 7'd60, 7'd100, 4'd0);
    wait_result("on_off_same_cycle", 0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 7'd61, 7'd100, 4'd0);
    evt.note_on = 1'b1; evt.note = 7'd90; evt.velocity = 7'd33;
    model_drop();
    @(negedge clk);
    idle_inputs();
    wait_result("drop_while_busy", 1, 1'b1);

    // Reset in the middle of a scan must abort the event
    @(negedge clk);
    evt.note_on = 1'b1; evt.note = 7'd77; evt.velocity = 7'd60;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_vec++;
    if (voice_gate !== '0 || voice_note !== '0 || drop_cnt !== '0 || evt.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_scan got gate=%b note=%h drop=%0d busy=%b want 0",
               voice_gate, voice_note, drop_cnt, evt.busy);
    end
    for (int k = 0; k < NV + 2; k++) begin
      @(negedge clk);
      n_vec++;
      if (voice_trig !== '0 || voice_gate !== '0) begin
        n_err++;
        $display("FAIL rst_no_trig cycle %0d got trig=%b gate=%b want 0", k, voice_trig, voice_gate);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_fill_steal();
    test_release();
    test_retrigger();
    test_vel0_and_orphan_off();
    test_back_to_back();
    test_drops();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator between the MIDI command decoder and the NUM_VOICES synth voice generators.
- Consumes the decoder's one-cycle note-on/note-off pulses and their note/velocity/channel, and assigns each note-on to a voice: retrigger a matching voice, else the first free voice, else steal the oldest.
- Note-offs release the voice holding the matching note/channel.
- Per-voice gate, pitch, velocity and channel registers feed the voice generators directly.

Parameters:
NUM_VOICES, 4, number of voices managed; legal 1..16
AGE_W, 8, width of per-voice age counters; saturating

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
note_on  in  1  one-cycle pulse, note-on event
note_off  in  1  one-cycle pulse, note-off event
note  in  7  MIDI note number, valid with pulse
velocity  in  7  MIDI velocity, valid with pulse
channel  in  4  MIDI channel, valid with pulse
busy  out  1  high while an accepted event is being processed
voice_gate  out  NUM_VOICES  per-voice gate, level
voice_trig  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned
voice_rel  out  NUM_VOICES  one-cycle pulse when a voice gate is cleared by note-off
voice_note  out  7*NUM_VOICES  per-voice note; voice i in bits [7i+6:7i]
voice_vel  out  7*NUM_VOICES  per-voice velocity; same packing
voice_chan  out  4*NUM_VOICES  per-voice channel; voice i in bits [4i+3:4i]
steal  out  1  one-cycle pulse when a note-on evicted a gated voice
drop_cnt  out  8  saturating count of events dropped

Behaviour:
- Reset: every output is 0, every age counter is 0, FSM is in IDLE, and any latched event is discarded.
- Reset asserted mid-scan aborts the event with no output update.
- FSM states:
  - IDLE: accepts an event.
  - SCAN: visits one voice per cycle, index 0..NUM_VOICES-1.
  - COMMIT: applies the result and returns to IDLE.
- Acceptance:
  - Events are sampled only in IDLE. note, velocity and channel are latched with the pulse.
  - A note_on with velocity==0 is treated as a note-off.
  - note_on and note_off in the same cycle: note_on is processed and note_off is dropped.
  - Any pulse arriving while busy=1 is dropped.
  - Each dropped event increments drop_cnt, which saturates at 255.
- Latency and busy:
  - An event is sampled at edge E0. busy is high after E0.
  - The state is SCAN index k after edge E0+k, and COMMIT after edge E0+NUM_VOICES.
  - Outputs update at edge E0+NUM_VOICES+1, which also returns the FSM to IDLE and drops busy.
  - busy is high for NUM_VOICES+1 cycles. A new event is accepted in the first cycle busy=0.
- SCAN bookkeeping (per visited voice i):
  - match: gate[i]=1 and note and channel equal the latched values. The lowest index wins.
  - free: gate[i]=0. The lowest index wins.
  - oldest: maximum age among gated voices. On a tie the lowest index wins.
- COMMIT, note-on:
  - Target selection priority: match > free > oldest.
  - Target gets gate=1, note/vel/chan loaded, age=0, and a voice_trig pulse.
  - Every other gated voice increments its age, saturating at 2^AGE_W-1.
  - steal pulses only when the target was chosen as oldest. A retrigger (match) is not a steal.
- COMMIT, note-off:
  - If there is a match: that voice gets gate=0 and a voice_rel pulse; note/vel/chan hold their values, so the release tail keeps its pitch.
  - If there is no match: no change to any voice.
- Pulses: voice_trig, voice_rel and steal are high for exactly one cycle after the update edge; they are 0 otherwise.
- With NUM_VOICES=1: a note-on always targets voice 0; steal fires when voice 0 is gated with a different note/channel.

Test Plan:
1. Reset, then note_on note=60 vel=100 ch=0 -> busy high 5 cycles; after edge E0+5, voice_gate=0001, voice 0 note=60 vel=100, voice_trig=0001 for 1 cycle, steal=0.
2. note_on 60, 62, 64, 65 (each sent after busy falls), then note_on 67 -> voices 0..3 filled in order; 67 steals voice 0 (age 3), steal pulses once, voice_gate=1111, voice 0 note=67.
3. Voices 0..2 hold 60/62/64; note_off 62 ch=0 -> voice_rel=0010 pulse, voice_gate=0101, voice 1 note stays 62; next note_on 70 lands in voice 1.
4. Voice 0 holds 60 ch=0; note_on 60 ch=0 vel=40 -> retrigger voice 0 (trig=0001, vel=40, steal=0); note_on 60 ch=1 -> goes to voice 1 (different channel).
5. note_on 72 vel=0 while voice 2 holds 72 -> treated as note-off: voice_rel=0100; note_off 99 with no holder -> no change, drop_cnt unchanged.
6. Pulse note_on during busy, and note_on+note_off in the same cycle -> drop_cnt increments by 1 each; assert rst during SCAN -> all outputs 0, no trig pulse afterwards.
